sqrt_feeder: RTL and testbench

//  Operand front-end and sequencer for the sqrt32 iterative core. Buffers 32-bit

---
 rtl/sqrt_feeder.sv | 236 +++++++++++++++++++++++
 tb/tb_sqrt_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_feeder
//  Purpose  : Operand FIFO and sequencer for the sqrt32 iterative core.
//             Operands from a valid/ready stream are queued and run through
//             the core one at a time. The core is held in reset while x
//             settles, then released until it raises rdy. Each 16-bit root is
//             presented on a valid/ready output stream in input order.
//  Options  : SQRT_FEED_TIMEOUT_EN - bound the RUN phase to TIMEOUT cycles.
//             On expiry, raise the sticky err flag and emit 16'hFFFF.
//  Revision : 1.0 - initial release
// ============================================================================
module sqrt_feeder #(
  parameter int DEPTH   = 4,   // operand FIFO entries, power of two, >= 2
  parameter int RST_CYC = 2,   // cycles core_reset is held per operation, >= 1
  parameter int TIMEOUT = 64   // RUN cycle limit when the timeout is built in
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        core_reset_o,
  output logic [31:0] core_x_o,
  input  logic        core_rdy_i,
  input  logic [15:0] core_y_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_data_o,
  output logic        busy_o,
  output logic        err_o
);

  // FIFO pointer width and phase-counter width. The counter is shared by the
  // LOAD hold-off and the RUN phase, so it is sized for the larger of the two.
  localparam int c_aw      = $clog2(DEPTH);
  localparam int c_cnt_max = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
  localparam int c_cw      = $clog2(c_cnt_max + 1);

  localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw:0]   c_fill_one = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);
  localparam logic [c_cw-1:0] c_cnt_zero = '0;
  localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
  localparam logic [c_cw-1:0] c_ld_last  = c_cw'(RST_CYC - 1);
`ifdef SQRT_FEED_TIMEOUT_EN
  localparam logic [c_cw-1:0] c_to_last  = c_cw'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [31:0]      mem_q [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_aw:0]    fill_q, fill_d;
  logic [c_cw-1:0]  cnt_q, cnt_d;
  logic [31:0]      core_x_q, core_x_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
`ifdef SQRT_FEED_TIMEOUT_EN
  logic             err_q, err_d;
`endif

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_head;

  assign w_full  = (fill_q == c_depth);
  assign w_empty = (fill_q == '0);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign w_push  = in_valid_i && !w_full;
  assign w_head  = mem_q[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Sequencer: next state, core operand, result capture and FIFO pop request
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    core_x_d    = core_x_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    w_pop       = 1'b0;
`ifdef SQRT_FEED_TIMEOUT_EN
    err_d       = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop    = 1'b1;
          core_x_d = w_head;
          cnt_d    = c_cnt_zero;
          state_d  = S_LOAD;
        end
      end

      // The core sits in reset with x already stable for RST_CYC cycles.
      S_LOAD: begin
        if (cnt_q == c_ld_last) begin
          cnt_d   = c_cnt_zero;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      // cnt_q == 0 marks the first RUN cycle. rdy may still be left over
      // from the previous operation then, so it is not trusted.
      S_RUN: begin
        if ((cnt_q != c_cnt_zero) && core_rdy_i) begin
          out_data_d  = core_y_i;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
`ifdef SQRT_FEED_TIMEOUT_EN
        end else if (cnt_q == c_to_last) begin
          err_d       = 1'b1;
          out_data_d  = 16'hFFFF;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
`else
        end else begin
          // Without a timeout, the counter only records that the first cycle
          // has passed, so it cannot overflow however long the core takes.
          cnt_d = c_cnt_one;
        end
`endif
      end

      // The result is held until it is accepted. The next operand is then
      // launched directly, without passing through IDLE.
      S_HOLD: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (!w_empty) begin
            w_pop    = 1'b1;
            core_x_d = w_head;
            cnt_d    = c_cnt_zero;
            state_d  = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = w_push ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
    rd_ptr_d = w_pop  ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;
    fill_d   = fill_q;
    unique case ({w_push, w_pop})
      2'b10:   fill_d = fill_q + c_fill_one;
      2'b01:   fill_d = fill_q - c_fill_one;
      default: fill_d = fill_q;
    endcase
  end

  // Operand storage. The contents are don't-care while unoccupied, so there is no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // Control and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      core_x_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      core_x_q    <= core_x_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef SQRT_FEED_TIMEOUT_EN
  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The core is released only in RUN. Reset forces IDLE, so it also
  // reinitialises the core.
  assign core_reset_o = (state_q != S_RUN);
  assign core_x_o     = core_x_q;
  assign in_ready_o   = !w_full;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign busy_o       = (state_q != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sqrt_feeder
//  Purpose  : Self-checking bench for sqrt_feeder. A behavioural stand-in for
//             the sqrt32 core has a random latency and leaves stale rdy/y
//             across its reset. Every accepted operand is scored against an
//             integer square root.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_feeder;

  localparam int DEPTH   = 4;
  localparam int RST_CYC = 2;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        core_reset;
  logic [31:0] core_x;
  logic        core_rdy = 1'b0;
  logic [15:0] core_y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  bit          core_dead = 1'b0;
  int unsigned core_cyc = 0;
  int unsigned core_lat = 1;

  always #5 clk = ~clk;

  sqrt_feeder #(
    .DEPTH   (DEPTH),
    .RST_CYC (RST_CYC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .core_reset_o (core_reset),
    .core_x_o     (core_x),
    .core_rdy_i   (core_rdy),
    .core_y_i     (core_y),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .busy_o       (busy),
    .err_o        (err)
  );

  // Reference: bitwise search for the largest r with r*r <= x
  function automatic logic [15:0] ref_isqrt(input logic [31:0] x);
    longint r = 0;
    longint c;
    for (int b = 15; b >= 0; b--) begin
      c = r + (longint'(1) << b);
      if (c * c <= longint'(x)) r = c;
    end
    return r[15:0];
  endfunction

  // Core stand-in: floating-point root, corrected to the exact floor
  function automatic logic [15:0] core_sqrt(input logic [31:0] x);
    longint xv = longint'(x);
    longint r  = longint'($rtoi($sqrt($itor(xv))));
    for (int k = 0; k < 4 && r * r > xv; k++) r = r - 1;
    for (int k = 0; k < 4 && (r + 1) * (r + 1) <= xv; k++) r = r + 1;
    return r[15:0];
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] s;
    case ($urandom_range(0, 4))
      0: return $urandom();
      1: return $urandom_range(0, 300);
      2: begin s = $urandom_range(0, 65535); return s * s; end
      3: return 32'hFFFF_FFFF - $urandom_range(0, 1000);
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sqrt32 stand-in: rdy/y persist through reset (stale), then update once released
  always @(posedge clk) begin
    if (core_reset) begin
      core_cyc <= 0;
      core_lat <= $urandom_range(1, 6);
    end else begin
      core_cyc <= core_cyc + 1;
      if (!core_dead && (core_cyc + 1 >= core_lat)) begin
        core_rdy <= 1'b1;
        core_y   <= core_sqrt(core_x);
      end else begin
        core_rdy <= 1'b0;
      end
    end
  end

  // Scoreboard: record accepted operands, check delivered results in order
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)
        exp_q.push_back(core_dead ? 16'hFFFF : ref_isqrt(in_data));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          check("unexpected_result", 32'(out_data), 32'hDEAD_BEEF);
        else
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic push(input logic [31:0] v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("push_stall", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle_check();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_core_reset", 32'(core_reset), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          n;
    bit          acc;
    int          sent;
    logic [31:0] dir_ops [5];

    // ---------------- reset values ----------------
    #1;
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_core_x", core_x, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_core_reset", 32'(core_reset), 32'd1);

    // ---------------- directed values, free-flowing output ----------------
    dir_ops[0] = 32'd0;
    dir_ops[1] = 32'd1;
    dir_ops[2] = 32'd16;
    dir_ops[3] = 32'd1000000;
    dir_ops[4] = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(dir_ops[i]);
    drain("t1_drain");
    idle_check();

    // ---------------- launch latency from an idle FIFO ----------------
    push(32'd144);                       // accepted at edge E0
    check("lat_e0_core_reset", 32'(core_reset), 32'd1);
    check("lat_e0_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;                  // E1: popped, LOAD entered
    check("lat_e1_core_x", core_x, 32'd144);
    check("lat_e1_core_reset", 32'(core_reset), 32'd1);
    @(posedge clk); #1;                  // E2: still LOAD
    check("lat_e2_core_reset", 32'(core_reset), 32'd1);
    @(posedge clk); #1;                  // E3: RUN, core released
    check("lat_e3_core_reset", 32'(core_reset), 32'd0);
    check("lat_e3_core_x", core_x, 32'd144);
    drain("lat_drain");

    // ---------------- back-pressure: FIFO fills, result held ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'd1000 + 32'(i * 7919));
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    check("bp_valid_rise", 32'(out_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'(exp_q[0]));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("bp_drain");
    idle_check();

    // ---------------- randomized traffic ----------------
    sent = 0;
    for (int c = 0; c < 4000 && sent < 40; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_data  = rand_operand();
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        in_valid = 1'b0;
        sent++;
      end
    end
    check("rand_sent", 32'(sent), 32'd40);
    out_ready = 1'b1;
    drain("rand_drain");
    idle_check();

    // ---------------- reset while RUN with three queued ----------------
    for (int i = 0; i < 4; i++) push(32'd50000 + 32'(i));
    check("rr_in_run", 32'(core_reset), 32'd0);
    check("rr_queued_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rr_out_valid", 32'(out_valid), 32'd0);
    check("rr_core_reset", 32'(core_reset), 32'd1);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_in_ready", 32'(in_ready), 32'd1);
    check("rr_core_x", core_x, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(32'd81);
    drain("rr_drain");
    idle_check();

`ifdef SQRT_FEED_TIMEOUT_EN
    // ---------------- timeout with a core that never answers ----------------
    core_dead = 1'b1;
    push(32'd123);
    drain("to_drain");
    check("to_err_set", 32'(err), 32'd1);
    core_dead = 1'b0;
    push(32'd49);
    drain("to_next_drain");
    check("to_err_sticky", 32'(err), 32'd1);
`else
    check("err_tied_low", 32'(err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
